sv_ram_ctrl: RTL and testbench

Request-side controller sitting directly upstream of the RAM wrapper. It accepts single-word read/write requests on a valid/ready handshake and converts them into the RAM's `cs`/`wr`/`rd` strobe protocol. It waits out the RAM's fixed read latency, captures `data_out`, and returns read data on a valid/ready response channel. At most one access is in flight at a time.

---
 rtl/sv_ram_ctrl.sv | 124 ++++++++++++
 tb/tb_sv_ram_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sv_ram_ctrl.sv
// sv_ram_ctrl: valid/ready request front-end for a single-port RAM with a fixed read latency.
// Define SV_RAM_CTRL_STATS_EN to add the saturating wr_cnt/rd_cnt access counters.
module sv_ram_ctrl #(
  parameter int unsigned AW         = 8,
  parameter int unsigned DW         = 8,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_wr,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic [AW-1:0] ram_address,
  output logic [DW-1:0] ram_data_in,
  output logic          ram_cs,
  output logic          ram_wr,
  output logic          ram_rd,
  input  logic [DW-1:0] ram_data_out
`ifdef SV_RAM_CTRL_STATS_EN
  ,
  output logic [15:0]   wr_cnt,
  output logic [15:0]   rd_cnt
`endif
);

  localparam int unsigned LW = 4;   // latency counter covers RD_LATENCY 1..15
  localparam int unsigned SW = 16;

  typedef enum logic [2:0] {IDLE, WR, RD, WAIT, RESP} state_t;

  state_t        state_q;
  state_t        state_d;
  logic [LW-1:0] lat_q;
  logic          accept_c;
  logic          last_wait_c;

  assign req_ready   = (state_q == IDLE);
  assign accept_c    = req_valid & req_ready;
  assign last_wait_c = (state_q == WAIT) && (lat_q == LW'(1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (req_valid) state_d = req_wr ? WR : RD;
      WR:   state_d = IDLE;
      RD:   state_d = WAIT;
      WAIT: if (lat_q == LW'(1)) state_d = RESP;
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with WR/RD exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_cs <= 1'b0;
      ram_wr <= 1'b0;
      ram_rd <= 1'b0;
    end else begin
      ram_cs <= (state_d == WR) || (state_d == RD);
      ram_wr <= (state_d == WR);
      ram_rd <= (state_d == RD);
    end
  end

  // Request payload capture; held while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_address <= '0;
      ram_data_in <= '0;
    end else if (accept_c) begin
      ram_address <= req_addr;
      if (req_wr) ram_data_in <= req_wdata;
    end
  end

  // Read latency counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_q <= '0;
    end else if (state_q == RD) begin
      lat_q <= LW'(RD_LATENCY);
    end else if (state_q == WAIT) begin
      lat_q <= lat_q - LW'(1);
    end
  end

  // Response channel; rsp_rdata holds its last capture after the handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= (state_d == RESP);
      if (last_wait_c) rsp_rdata <= ram_data_out;
    end
  end

`ifdef SV_RAM_CTRL_STATS_EN
  // Saturating access counters, one count per strobe cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (ram_wr && (wr_cnt != '1)) wr_cnt <= wr_cnt + SW'(1);
      if (ram_rd && (rd_cnt != '1)) rd_cnt <= rd_cnt + SW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_sv_ram_ctrl.sv
// tb_sv_ram_ctrl: self-checking bench for sv_ram_ctrl with behavioural RAMs at latency 1 and 3.
// Read data is checked through a scoreboard queue; strobe invariants are checked every cycle.
module tb_sv_ram_ctrl;

  localparam int unsigned LAT1 = 1;
  localparam int unsigned LAT3 = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DUT with RD_LATENCY = 1
  logic       req_valid, req_ready, req_wr, rsp_valid, rsp_ready;
  logic [7:0] req_addr, req_wdata, rsp_rdata;
  logic [7:0] ram_address, ram_data_in, ram_data_out;
  logic       ram_cs, ram_wr, ram_rd;
  // DUT with RD_LATENCY = 3
  logic       req_valid3, req_ready3, req_wr3, rsp_valid3, rsp_ready3;
  logic [7:0] req_addr3, req_wdata3, rsp_rdata3;
  logic [7:0] ram_address3, ram_data_in3, ram_data_out3;
  logic       ram_cs3, ram_wr3, ram_rd3;
`ifdef SV_RAM_CTRL_STATS_EN
  logic [15:0] wr_cnt, rd_cnt, wr_cnt3, rd_cnt3;
`endif

  sv_ram_ctrl #(.AW(8), .DW(8), .RD_LATENCY(LAT1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .ram_address(ram_address), .ram_data_in(ram_data_in),
    .ram_cs(ram_cs), .ram_wr(ram_wr), .ram_rd(ram_rd),
    .ram_data_out(ram_data_out)
`ifdef SV_RAM_CTRL_STATS_EN
    , .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
`endif
  );

  sv_ram_ctrl #(.AW(8), .DW(8), .RD_LATENCY(LAT3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_wr(req_wr3),
    .req_addr(req_addr3), .req_wdata(req_wdata3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_rdata(rsp_rdata3),
    .ram_address(ram_address3), .ram_data_in(ram_data_in3),
    .ram_cs(ram_cs3), .ram_wr(ram_wr3), .ram_rd(ram_rd3),
    .ram_data_out(ram_data_out3)
`ifdef SV_RAM_CTRL_STATS_EN
    , .wr_cnt(wr_cnt3), .rd_cnt(rd_cnt3)
`endif
  );

  // Behavioural RAMs: read data is valid for exactly one cycle, EE otherwise
  logic [7:0] mem1 [256];
  logic [7:0] mem3 [256];
  logic [7:0] pipe3_0, pipe3_1, pipe3_2;

  always @(posedge clk) begin
    if (ram_cs && ram_wr) mem1[ram_address] <= ram_data_in;
    ram_data_out <= (ram_cs && ram_rd) ? mem1[ram_address] : 8'hEE;
  end

  always @(posedge clk) begin
    if (ram_cs3 && ram_wr3) mem3[ram_address3] <= ram_data_in3;
    pipe3_0 <= (ram_cs3 && ram_rd3) ? mem3[ram_address3] : 8'hEE;
    pipe3_1 <= pipe3_0;
    pipe3_2 <= pipe3_1;
  end
  assign ram_data_out3 = pipe3_2;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: expected read data pushed on accept, popped on response handshake
  logic [7:0] sb_q[$];
  logic [7:0] exp_drv;
  logic [7:0] sb_exp;
  logic       cs_prev, cs_prev3;

  always @(negedge rst_n) sb_q.delete();

  always @(negedge clk) begin
    if (!rst_n) begin
      cs_prev  = 1'b0;
      cs_prev3 = 1'b0;
    end else begin
      if (req_valid && req_ready && !req_wr) sb_q.push_back(exp_drv);
      if (rsp_valid && rsp_ready) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected_rsp: got rdata %0h with no read outstanding", rsp_rdata);
        end else begin
          sb_exp = sb_q.pop_front();
          if (rsp_rdata !== sb_exp) begin
            n_fail++;
            $display("FAIL sb_rdata: got %0h expected %0h at %0t", rsp_rdata, sb_exp, $time);
          end
        end
      end
      check("wr_rd_overlap", 32'(ram_wr & ram_rd), 0);
      check("cs_encoding", 32'(ram_cs), 32'(ram_wr | ram_rd));
      check("cs_pulse_width", 32'(ram_cs & cs_prev), 0);
      check("wr_rd_overlap3", 32'(ram_wr3 & ram_rd3), 0);
      check("cs_encoding3", 32'(ram_cs3), 32'(ram_wr3 | ram_rd3));
      check("cs_pulse_width3", 32'(ram_cs3 & cs_prev3), 0);
      cs_prev  = ram_cs;
      cs_prev3 = ram_cs3;
    end
  end

  // Single request on the latency-1 DUT; reads return once rsp_valid is seen
  task automatic do_req(input logic wr, input logic [7:0] addr, input logic [7:0] data);
    int j;
    @(posedge clk); #1;
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = data; exp_drv = data;
    j = 0;
    @(negedge clk);
    while (!req_ready && j < 20) begin @(negedge clk); j++; end
    check("req_accept", 32'(req_ready), 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("strobe_cs", 32'(ram_cs), 1);
    check("strobe_wr", 32'(ram_wr), 32'(wr));
    check("strobe_rd", 32'(ram_rd), 32'(!wr));
    check("strobe_addr", 32'(ram_address), 32'(addr));
    check("busy_ready", 32'(req_ready), 0);
    if (wr) begin
      check("wr_data_in", 32'(ram_data_in), 32'(data));
      @(negedge clk);
      check("wr_ready_back", 32'(req_ready), 1);
    end else begin
      j = 1;
      @(negedge clk);
      while (!rsp_valid && j < 20) begin
        check("wait_no_strobe", 32'(ram_cs), 0);
        @(negedge clk);
        j++;
      end
      check("rd_latency", 32'(j), 32'(1 + LAT1));
      if (rsp_ready) begin
        @(negedge clk);
        check("rd_ready_back", 32'(req_ready), 1);
        check("rd_valid_drop", 32'(rsp_valid), 0);
      end
    end
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;   // write data, or expected read data
  } vec_t;

  vec_t vec[8];
  vec_t bb[4];

  initial begin
    int n;
    int j;
    logic prev_wr;

    vec[0] = '{1'b1, 8'h12, 8'hA5};
    vec[1] = '{1'b0, 8'h12, 8'hA5};
    vec[2] = '{1'b1, 8'h34, 8'h5A};
    vec[3] = '{1'b1, 8'hFF, 8'h01};
    vec[4] = '{1'b0, 8'h34, 8'h5A};
    vec[5] = '{1'b0, 8'hFF, 8'h01};
    vec[6] = '{1'b1, 8'h00, 8'hC3};
    vec[7] = '{1'b0, 8'h00, 8'hC3};
    bb[0]  = '{1'b1, 8'h40, 8'h11};
    bb[1]  = '{1'b0, 8'h40, 8'h11};
    bb[2]  = '{1'b1, 8'h41, 8'h22};
    bb[3]  = '{1'b0, 8'h41, 8'h22};

    rst_n = 1'b0;
    req_valid = 1'b0; req_wr = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
    rsp_ready = 1'b1; exp_drv = 8'h00;
    req_valid3 = 1'b0; req_wr3 = 1'b0; req_addr3 = 8'h00; req_wdata3 = 8'h00;
    rsp_ready3 = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 0);
    check("rst_strobes", 32'({ram_cs, ram_wr, ram_rd}), 0);
    check("rst_address", 32'(ram_address), 0);
    check("rst_data_in", 32'(ram_data_in), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_ready", 32'(req_ready), 1);

    // Table-driven write/read traffic
    for (int i = 0; i < 8; i++) do_req(vec[i].wr, vec[i].addr, vec[i].data);

    // Backpressure: response held five cycles
    rsp_ready = 1'b0;
    do_req(1'b0, 8'h12, 8'hA5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(rsp_valid), 1);
      check("bp_rdata", 32'(rsp_rdata), 32'h0000_00A5);
      check("bp_ready", 32'(req_ready), 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_valid_drop", 32'(rsp_valid), 0);
    check("bp_idle", 32'(req_ready), 1);
    check("bp_rdata_hold", 32'(rsp_rdata), 32'h0000_00A5);

    // Back-to-back with req_valid held high
    @(posedge clk); #1;
    req_valid = 1'b1; req_wr = bb[0].wr; req_addr = bb[0].addr;
    req_wdata = bb[0].data; exp_drv = bb[0].data;
    prev_wr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      if (i > 0) check("b2b_gap", 32'(n), prev_wr ? 32'd1 : 32'(2 + LAT1));
      check("b2b_accept", 32'(req_ready), 1);
      prev_wr = bb[i].wr;
      @(posedge clk); #1;
      if (i < 3) begin
        req_wr = bb[i+1].wr; req_addr = bb[i+1].addr;
        req_wdata = bb[i+1].data; exp_drv = bb[i+1].data;
      end else begin
        req_valid = 1'b0;
      end
    end
    repeat (6) @(negedge clk);
    check("b2b_sb_empty", 32'(sb_q.size()), 0);

    // Read latency 3 on the second DUT
    @(posedge clk); #1;
    req_valid3 = 1'b1; req_wr3 = 1'b1; req_addr3 = 8'h55; req_wdata3 = 8'h77;
    @(negedge clk);
    check("l3_wr_accept", 32'(req_ready3), 1);
    @(posedge clk); #1;
    req_valid3 = 1'b0;
    @(negedge clk);
    check("l3_wr_strobe", 32'({ram_cs3, ram_wr3, ram_rd3}), 32'b110);
    @(posedge clk); #1;
    req_valid3 = 1'b1; req_wr3 = 1'b0;
    @(negedge clk);
    check("l3_rd_accept", 32'(req_ready3), 1);
    @(posedge clk); #1;
    req_valid3 = 1'b0;
    @(negedge clk);
    check("l3_rd_strobe", 32'({ram_cs3, ram_wr3, ram_rd3}), 32'b101);
    j = 1;
    @(negedge clk);
    while (!rsp_valid3 && j < 20) begin
      check("l3_wait_no_strobe", 32'({ram_cs3, ram_wr3, ram_rd3}), 0);
      @(negedge clk);
      j++;
    end
    check("l3_latency", 32'(j), 32'(1 + LAT3));
    check("l3_rdata", 32'(rsp_rdata3), 32'h0000_0077);
    @(negedge clk);
    check("l3_valid_drop", 32'(rsp_valid3), 0);
    check("l3_ready_back", 32'(req_ready3), 1);

    // Asynchronous reset while a read is in WAIT
    @(posedge clk); #1;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 8'h34; exp_drv = 8'h5A;
    @(negedge clk);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_rsp_valid", 32'(rsp_valid), 0);
    check("arst_rsp_rdata", 32'(rsp_rdata), 0);
    check("arst_strobes", 32'({ram_cs, ram_wr, ram_rd}), 0);
    check("arst_address", 32'(ram_address), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_release_ready", 32'(req_ready), 1);
    @(negedge clk);
    check("arst_no_rsp", 32'(rsp_valid), 0);

`ifdef SV_RAM_CTRL_STATS_EN
    // Access counters and saturation
    do_req(1'b1, 8'h01, 8'h10);
    do_req(1'b1, 8'h02, 8'h20);
    do_req(1'b1, 8'h03, 8'h30);
    do_req(1'b0, 8'h01, 8'h10);
    do_req(1'b0, 8'h02, 8'h20);
    @(negedge clk);
    check("stats_wr_cnt", 32'(wr_cnt), 3);
    check("stats_rd_cnt", 32'(rd_cnt), 2);
    force u_dut.wr_cnt = 16'hFFFE;
    @(posedge clk); #1;
    release u_dut.wr_cnt;
    do_req(1'b1, 8'h04, 8'h40);
    do_req(1'b1, 8'h05, 8'h50);
    @(negedge clk);
    check("stats_wr_sat", 32'(wr_cnt), 32'h0000_FFFF);
`endif

    repeat (3) @(negedge clk);
    check("final_sb_empty", 32'(sb_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
